xnor_serial_cmp: RTL and testbench
==================================

# xnor_serial_cmp

Bit-serial word comparator that time-shares one XNOR gate instance between two requesters. Each granted request captures two WIDTH-bit operands and shifts them through the single XNOR, LSB first, one bit per cycle. It returns a full-word equality flag and a count of matching bit positions. It sits in the logic-gates tier as the first sequenced consumer of the elementary gates, and is intended for Hack-word (16-bit) compare checks in the demo core.

## Interface
Parameters:
- WIDTH, default 16: operand width in bits; legal range ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0  in  1  requester 0 request.
- a0, b0  in  WIDTH each  requester 0 operands; must be stable while req0 is high and grant0 has not yet been seen.
- req1  in  1  requester 1 request.
- a1, b1  in  WIDTH each  requester 1 operands; same stability rule as requester 0.
- grant0, grant1  out  1 each  one-cycle pulse; operands of the granted requester are captured on the clock edge that ends this cycle.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse; the result is valid.
- done_id  out  1  index of the requester the current result belongs to.
- eq  out  1  1 when all WIDTH bit pairs matched.
- match_cnt  out  $clog2(WIDTH+1)  number of matching bit positions, 0..WIDTH.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - If req0 or req1 is high, the arbiter picks a winner and the FSM goes to LOAD.
  - Otherwise the FSM stays in IDLE.
- LOAD:
  - grant of the winner is high for exactly this cycle.
  - The winner's a/b are loaded into internal shift registers sa and sb.
  - The bit counter, match accumulator and eq accumulator are cleared.
  - The winner's id is latched.
  - Next state is SHIFT.
- SHIFT, exactly WIDTH cycles:
  - The XNOR instance is fed sa[0] and sb[0].
  - The XNOR output is added to the match accumulator and ANDed into the eq accumulator (which starts at 1).
  - sa and sb shift right by one.
  - After the WIDTH-th bit the FSM goes to DONE.
- DONE:
  - done=1 for one cycle.
  - eq, match_cnt and done_id are updated this cycle.
  - Next state is always IDLE.
- Result outputs hold their values until the next DONE. They do not change in LOAD or SHIFT.
- Arbitration is two-way round-robin:
  - A register last_id holds the most recently served requester; its reset value is 1, so requester 0 wins the first tie.
  - On a tie, the grant goes to !last_id.
  - With a single requester, that requester is granted regardless of last_id.
- A requester may drop req any time after its grant. If req is still high when the FSM returns to IDLE, it is treated as a new request.
- Invariant: eq == (match_cnt == WIDTH).
- Arithmetic: the match counter is $clog2(WIDTH+1) bits wide and cannot overflow, because it increments at most WIDTH times.

## Timing
- Reset (reset_n low at a rising edge):
  - FSM goes to IDLE, last_id=1.
  - grant0, grant1, busy, done, done_id, eq and match_cnt are all 0.
  - An in-flight operation is discarded; no done is produced for it.
- Reset takes priority over every other event, including a DONE cycle.
- Latency: a req high in cycle T, with the FSM in IDLE, gives:
  - grant in T+1;
  - SHIFT in T+2 through T+1+WIDTH;
  - done in T+2+WIDTH.
- Throughput: with back-to-back requests, one result every WIDTH+3 cycles. IDLE always lasts at least one cycle between operations.
- busy:
  - goes high in the LOAD cycle;
  - stays high through the DONE cycle;
  - is low in IDLE.
- Requests arriving while busy are not acknowledged; they wait and are arbitrated at the next IDLE.
- grant0 and grant1 are never high together. At most one grant pulse occurs per done pulse.

## Structure
- Shared package: HACK_WORD_WIDTH=16, used as the WIDTH default.
- Local to this module:
  - FSM state encoding, 2-bit localparams.
  - The counter width expression.
- Exactly one XNOR instance (the existing elementary gate). No behavioural `~^` is used for the compare.
- One natural sub-module: rr_arb2, the two-requester round-robin arbiter. It contains the last_id register, takes req0, req1 and an update strobe (the LOAD cycle), and outputs the winner id.

## Test plan
- Reset/idle:
  - reset_n low for 2 cycles, then high, no requests, for 10 cycles -> all outputs 0, busy 0.
- Single match:
  - req0 with a0=b0=16'hBEEF -> grant0 one cycle after req;
  - done exactly 18 cycles after req, with eq=1, match_cnt=16, done_id=0.
- Partial mismatch:
  - req1 with a1=16'h00FF, b1=16'h0F0F -> done_id=1, eq=0, match_cnt=8.
- Tie and round-robin:
  - After reset, req0 and req1 high together, operands 16'h0000/16'hFFFF for both -> grant0 first (match_cnt=0), then grant1 next;
  - grants alternate 0,1,0,1 while both are held high;
  - one done every 19 cycles.
- Reset mid-operation:
  - Assert reset_n low during the 7th SHIFT cycle -> no done, all outputs 0 next cycle;
  - a new req0 afterwards completes normally in 18 cycles.
- Result hold:
  - After a result with match_cnt=16, start a request with 16'h0001 vs 16'h0000 -> eq/match_cnt stay 1/16 during LOAD and SHIFT, then become 0/15 at done.

Source files
------------

// File: rtl/xnor_serial_cmp_pkg.sv
// Shared definitions for the bit-serial XNOR word comparator.
package xnor_serial_cmp_pkg;
    localparam int HACK_WORD_WIDTH = 16;

    typedef logic req_id_t;
endpackage

// File: rtl/xnor_serial_cmp_if.sv
// Request/operand/result bundle between the two requesters and the comparator.
interface xnor_serial_cmp_if
    import xnor_serial_cmp_pkg::*;
#(
    parameter int WIDTH = HACK_WORD_WIDTH
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             grant0;
    logic             grant1;
    logic             busy;
    logic             done;
    req_id_t          done_id;
    logic             eq;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  grant0, grant1, busy, done, done_id, eq, match_cnt
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output grant0, grant1, busy, done, done_id, eq, match_cnt
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; last_id remembers the most recently served side.
module rr_arb2
    import xnor_serial_cmp_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    req0,
    input  logic    req1,
    input  logic    upd,
    input  req_id_t upd_id,
    output req_id_t win_id
);
    req_id_t last_id_q;
    req_id_t last_id_d;

    // Winner selection: a tie goes to the side not served last.
    always_comb begin
        win_id = 1'b0;
        if (req0 && req1) begin
            win_id = ~last_id_q;
        end else if (req1) begin
            win_id = 1'b1;
        end else begin
            win_id = 1'b0;
        end
    end

    // Record the served requester when the comparator loads its operands.
    always_comb begin
        last_id_d = last_id_q;
        if (upd) begin
            last_id_d = upd_id;
        end else begin
            last_id_d = last_id_q;
        end
    end

    // last_id register; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_id_q <= 1'b1;
        end else begin
            last_id_q <= last_id_d;
        end
    end
endmodule

// File: rtl/xnor_gate.sv
// Elementary two-input XNOR gate.
module xnor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a ^ b);
endmodule

// File: rtl/xnor_serial_cmp.sv
// Bit-serial word comparator sharing one XNOR gate between two requesters,
// reporting full-word equality and the number of matching bit positions.
module xnor_serial_cmp
    import xnor_serial_cmp_pkg::*;
#(
    parameter int WIDTH = HACK_WORD_WIDTH
)(
    input  logic               clk,
    input  logic               reset_n,
    xnor_serial_cmp_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

    state_e           state_q,     state_d;
    req_id_t          id_q,        id_d;
    logic [WIDTH-1:0] sa_q,        sa_d;
    logic [WIDTH-1:0] sb_q,        sb_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [CNT_W-1:0] match_acc_q, match_acc_d;
    logic             eq_acc_q,    eq_acc_d;
    logic             grant0_q,    grant0_d;
    logic             grant1_q,    grant1_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    req_id_t          done_id_q,   done_id_d;
    logic             eq_q,        eq_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

    logic    xnor_bit_s;
    req_id_t arb_win_s;
    logic    arb_upd_s;

    assign arb_upd_s = (state_q == LOAD);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (bus.req0),
        .req1    (bus.req1),
        .upd     (arb_upd_s),
        .upd_id  (id_q),
        .win_id  (arb_win_s)
    );

    xnor_gate u_xnor (
        .a (sa_q[0]),
        .b (sb_q[0]),
        .y (xnor_bit_s)
    );

    // Next-state and datapath; grant/busy/done are computed one edge early so they leave flops.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        bit_cnt_d   = bit_cnt_q;
        match_acc_d = match_acc_q;
        eq_acc_d    = eq_acc_q;
        grant0_d    = 1'b0;
        grant1_d    = 1'b0;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        eq_d        = eq_q;
        match_cnt_d = match_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d  = LOAD;
                    id_d     = arb_win_s;
                    grant0_d = ~arb_win_s;
                    grant1_d = arb_win_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                sa_d        = id_q ? bus.a1 : bus.a0;
                sb_d        = id_q ? bus.b1 : bus.b0;
                bit_cnt_d   = '0;
                match_acc_d = '0;
                eq_acc_d    = 1'b1;
                state_d     = SHIFT;
            end
            SHIFT: begin
                match_acc_d = match_acc_q + CNT_W'(xnor_bit_s);
                eq_acc_d    = eq_acc_q & xnor_bit_s;
                sa_d        = sa_q >> 1;
                sb_d        = sb_q >> 1;
                bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    // Results publish on entry to DONE so they are visible during it.
                    state_d     = DONE;
                    done_d      = 1'b1;
                    eq_d        = eq_acc_d;
                    match_cnt_d = match_acc_d;
                    done_id_d   = id_q;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            sa_q        <= '0;
            sb_q        <= '0;
            bit_cnt_q   <= '0;
            match_acc_q <= '0;
            eq_acc_q    <= 1'b0;
            grant0_q    <= 1'b0;
            grant1_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            eq_q        <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            bit_cnt_q   <= bit_cnt_d;
            match_acc_q <= match_acc_d;
            eq_acc_q    <= eq_acc_d;
            grant0_q    <= grant0_d;
            grant1_q    <= grant1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            eq_q        <= eq_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bus.grant0    = grant0_q;
    assign bus.grant1    = grant1_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.eq        = eq_q;
    assign bus.match_cnt = match_cnt_q;
endmodule

// File: tb/tb_xnor_serial_cmp.sv
// Self-checking bench: timeline-based reference model, per-cycle compare, directed and random phases.
module tb_xnor_serial_cmp;
    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    xnor_serial_cmp_if #(.WIDTH(W)) bus ();

    xnor_serial_cmp #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_matches(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        for (int i = 0; i < W; i++) begin
            if (a[i] == b[i]) n++;
        end
        return n;
    endfunction

    // ---------------- reference model: operation timeline ----------------
    int   cyc = 0;
    logic m_active = 1'b0;
    int   m_tgrant = 0;
    int   m_tdone = 0;
    logic m_id = 1'b0;
    logic m_last = 1'b1;
    int   m_pend = 0;
    logic exp_grant0 = 1'b0, exp_grant1 = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    logic exp_id = 1'b0, exp_eq = 1'b0;
    logic [CW-1:0] exp_cnt = '0;

    wire m_idle  = !(m_active && (cyc <= m_tdone));
    wire m_start = m_idle && (bus.req0 || bus.req1);
    wire m_win   = (bus.req0 && bus.req1) ? !m_last : bus.req1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            m_active   <= 1'b0;
            m_last     <= 1'b1;
            exp_grant0 <= 1'b0;
            exp_grant1 <= 1'b0;
            exp_busy   <= 1'b0;
            exp_done   <= 1'b0;
            exp_id     <= 1'b0;
            exp_eq     <= 1'b0;
            exp_cnt    <= '0;
        end else begin
            if (m_start) begin
                m_active <= 1'b1;
                m_tgrant <= cyc + 1;
                m_tdone  <= cyc + 2 + W;
                m_id     <= m_win;
                m_last   <= m_win;
            end
            if (m_active && cyc == m_tgrant)
                m_pend <= m_id ? count_matches(bus.a1, bus.b1) : count_matches(bus.a0, bus.b0);
            exp_grant0 <= m_start && !m_win;
            exp_grant1 <= m_start && m_win;
            exp_busy   <= m_start || (m_active && (cyc + 1 <= m_tdone));
            exp_done   <= m_active && (cyc + 1 == m_tdone);
            if (m_active && (cyc + 1 == m_tdone)) begin
                exp_eq  <= (m_pend == W);
                exp_cnt <= CW'(m_pend);
                exp_id  <= m_id;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant0", 32'(bus.grant0), 32'(exp_grant0));
            chk("grant1", 32'(bus.grant1), 32'(exp_grant1));
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("done", 32'(bus.done), 32'(exp_done));
            chk("done_id", 32'(bus.done_id), 32'(exp_id));
            chk("eq", 32'(bus.eq), 32'(exp_eq));
            chk("match_cnt", 32'(bus.match_cnt), 32'(exp_cnt));
            chk("eq_invariant", 32'(bus.eq), 32'(bus.match_cnt == CW'(W)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int id, input logic v);
        if (id == 0) bus.req0 = v;
        else         bus.req1 = v;
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin bus.a0 = a; bus.b0 = b; end
        else         begin bus.a1 = a; bus.b1 = b; end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Runs one request from an IDLE cycle; optionally checks that old results hold until done.
    task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic xeq, input int xcnt,
                         input logic hold, input logic heq, input int hcnt);
        logic seen = 1'b0;
        @(negedge clk); #1;
        set_ops(id, a, b);
        set_req(id, 1'b1);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) begin
                chk("op_grant", 32'(id ? bus.grant1 : bus.grant0), 32'd1);
                #1 set_req(id, 1'b0);
            end
            if (bus.done) begin
                chk("op_latency", 32'(n), 32'(W + 2));
                chk("op_eq", 32'(bus.eq), 32'(xeq));
                chk("op_cnt", 32'(bus.match_cnt), 32'(xcnt));
                chk("op_id", 32'(bus.done_id), 32'(id));
                seen = 1'b1;
                break;
            end else if (hold) begin
                chk("hold_eq", 32'(bus.eq), 32'(heq));
                chk("hold_cnt", 32'(bus.match_cnt), 32'(hcnt));
            end
        end
        if (!seen) chk("op_timeout", 32'd0, 32'd1);
    endtask

    task automatic rand_requester(input int id, input int ncyc);
        logic seen = 1'b0;
        logic on = 1'b0;
        logic [W-1:0] a, b;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if ((id == 0 && bus.grant0) || (id == 1 && bus.grant1)) seen = 1'b1;
            #1;
            if (!on) begin
                if ($urandom_range(2) == 0) begin
                    a = W'($urandom);
                    case ($urandom_range(3))
                        0: b = a;
                        1: b = a ^ (W'(1) << $urandom_range(W - 1));
                        2: b = ~a;
                        default: b = W'($urandom);
                    endcase
                    set_ops(id, a, b);
                    on = 1'b1;
                    seen = 1'b0;
                    set_req(id, 1'b1);
                end
            end else if (seen && $urandom_range(1) == 0) begin
                on = 1'b0;
                set_req(id, 1'b0);
            end
        end
        set_req(id, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int dones;
        int last_done;
        int gq[$];
        int n;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;

        // reset and idle
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk); #1;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_cnt", 32'(bus.match_cnt), 32'd0);
        chk("idle_eq", 32'(bus.eq), 32'd0);

        // single match and partial mismatch
        do_op(0, 16'hBEEF, 16'hBEEF, 1'b1, 16, 1'b0, 1'b0, 0);
        do_op(1, 16'h00FF, 16'h0F0F, 1'b0, 8, 1'b0, 1'b0, 0);

        // tie and round robin from reset
        do_reset();
        @(negedge clk); #1;
        set_ops(0, 16'h0000, 16'hFFFF);
        set_ops(1, 16'h0000, 16'hFFFF);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        dones = 0; last_done = 0; n = 0;
        while (dones < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.grant0) gq.push_back(0);
            if (bus.grant1) gq.push_back(1);
            if (bus.done) begin
                chk("tie_cnt", 32'(bus.match_cnt), 32'd0);
                chk("tie_done_id", 32'(bus.done_id), 32'(dones % 2));
                if (dones > 0) chk("tie_spacing", 32'(n - last_done), 32'(W + 3));
                last_done = n;
                dones++;
            end
        end
        #1 bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("tie_dones", 32'(dones), 32'd4);
        chk("tie_grants", 32'(gq.size()), 32'd4);
        for (int i = 0; i < gq.size(); i++) chk("tie_grant_order", 32'(gq[i]), 32'(i % 2));

        // reset during the 7th SHIFT cycle
        @(negedge clk); #1;
        set_ops(0, 16'h1234, 16'h1234);
        bus.req0 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) #1 bus.req0 = 1'b0;
        end
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_eq", 32'(bus.eq), 32'd0);
        chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
        #1 reset_n = 1'b1;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        chk("rst_no_done", 32'(n), 32'd0);
        do_op(0, 16'hAAAA, 16'hAAAA, 1'b1, 16, 1'b0, 1'b0, 0);

        // result hold through LOAD and SHIFT
        do_op(0, 16'hBEEF, 16'hBEEF, 1'b1, 16, 1'b0, 1'b0, 0);
        do_op(1, 16'h0001, 16'h0000, 1'b0, 15, 1'b1, 1'b1, 16);

        // randomized contention
        fork
            rand_requester(0, 800);
            rand_requester(1, 800);
        join
        repeat (W + 8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
